// File: rtl/chacha_stream_ctrl.sv
// rtl/chacha_stream_ctrl.sv - ChaCha20 byte-stream sequencer: config regs, core state load, keystream XOR.
// Optional feature macro: CHACHA_CTRL_OVERFLOW_EN (halt with sticky err when the block counter wraps).
module chacha_stream_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_we,
  input  logic [5:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic       start,
  input  logic       stop,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [7:0] core_data_in,
  output logic       core_write,
  output logic [5:0] core_addr,
  input  logic [7:0] core_data_out,
  input  logic       core_ready,
  output logic       busy,
  output logic       err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_STREAM = 2'd3;

  // "expand 32-byte k", word 0 in the low bits, bytes little-endian.
  localparam logic [127:0] SIGMA = 128'h6b20_6574_7962_2d32_3320_646e_6170_7865;

  logic [1:0]   state;
  logic [5:0]   idx;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  counter;

  logic         xfer;
  logic         last_xfer;
  logic         start_ok;
  logic         wrap_stop;
  logic [4:0]   key_sel;
  logic [3:0]   nonce_sel;
  logic [3:0]   nonce_wsel;
  logic [7:0]   load_byte;

  assign start_ok   = (state == S_IDLE) && start && !cfg_we;
  assign xfer       = (state == S_STREAM) && in_valid && out_ready;
  assign last_xfer  = xfer && (idx == 6'd63);
  assign nonce_wsel = 4'(cfg_addr - 6'd32);

`ifdef CHACHA_CTRL_OVERFLOW_EN
  assign wrap_stop = last_xfer && (counter == 32'hffff_ffff);
`else
  assign wrap_stop = 1'b0;
`endif

  // Byte idx of the 64-byte initial state: constants, key, counter, nonce.
  always_comb begin
    key_sel   = 5'(idx - 6'd16);
    nonce_sel = 4'(idx - 6'd52);
    if (idx < 6'd16)
      load_byte = SIGMA[{idx[3:0], 3'b000} +: 8];
    else if (idx < 6'd48)
      load_byte = key[{key_sel, 3'b000} +: 8];
    else if (idx < 6'd52)
      load_byte = counter[{idx[1:0], 3'b000} +: 8];
    else
      load_byte = nonce[{nonce_sel, 3'b000} +: 8];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= 6'd0;
      key     <= '0;
      nonce   <= '0;
      counter <= '0;
    end else if ((state != S_IDLE) && stop) begin
      state <= S_IDLE;
      idx   <= 6'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_we) begin
            if (cfg_addr < 6'd32)
              key[{cfg_addr[4:0], 3'b000} +: 8] <= cfg_data;
            else if (cfg_addr < 6'd44)
              nonce[{nonce_wsel, 3'b000} +: 8] <= cfg_data;
            else if (cfg_addr < 6'd48)
              counter[{cfg_addr[1:0], 3'b000} +: 8] <= cfg_data;
          end else if (start_ok) begin
            state <= S_LOAD;
            idx   <= 6'd0;
          end
        end
        S_LOAD: begin
          idx <= idx + 6'd1;
          if (idx == 6'd63)
            state <= S_WAIT;
        end
        S_WAIT: begin
          if (core_ready) begin
            state <= S_STREAM;
            idx   <= 6'd0;
          end
        end
        S_STREAM: begin
          if (xfer)
            idx <= idx + 6'd1;
          // Counter wraps modulo 2^32 either way; overflow mode only changes where we go next.
          if (last_xfer) begin
            counter <= counter + 32'd1;
            state   <= wrap_stop ? S_IDLE : S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CHACHA_CTRL_OVERFLOW_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (start_ok)
      err_q <= 1'b0;
    else if (wrap_stop && !stop)
      err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy         = (state != S_IDLE);
  assign core_write   = (state == S_LOAD);
  assign core_data_in = (state == S_LOAD) ? load_byte : 8'd0;
  assign core_addr    = (state == S_STREAM) ? idx : 6'd0;
  assign out_valid    = (state == S_STREAM) && in_valid;
  assign in_ready     = (state == S_STREAM) && out_ready;
  assign out_data     = (state == S_STREAM) ? (in_data ^ core_data_out) : 8'd0;

endmodule

// File: tb/tb_chacha_stream_ctrl.sv
// tb/tb_chacha_stream_ctrl.sv - randomized bench for chacha_stream_ctrl with a ChaCha20 core model and reference.
module tb_chacha_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [5:0] cfg_addr = 6'd0;
  logic [7:0] cfg_data = 8'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, core_write, core_ready, busy, err;
  logic [7:0] out_data, core_data_in, core_data_out;
  logic [5:0] core_addr;

`ifdef CHACHA_CTRL_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  chacha_stream_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .stop(stop), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_data_in(core_data_in), .core_write(core_write), .core_addr(core_addr),
    .core_data_out(core_data_out), .core_ready(core_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [511:0] chacha(input logic [511:0] init);
    logic [31:0] x [16];
    logic [31:0] s [16];
    logic [511:0] r;
    for (int i = 0; i < 16; i++) begin
      s[i] = init[32*i +: 32];
      x[i] = s[i];
    end
    for (int rnd = 0; rnd < 10; rnd++) begin
      for (int q = 0; q < 8; q++) begin
        int a, b, c, d, j;
        j = q % 4;
        a = j;
        if (q < 4) begin
          b = 4 + j; c = 8 + j; d = 12 + j;
        end else begin
          b = 4 + (j + 1) % 4; c = 8 + (j + 2) % 4; d = 12 + (j + 3) % 4;
        end
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
      end
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
    return r;
  endfunction

  function automatic logic [511:0] img(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    string sig;
    logic [127:0] s;
    sig = "expand 32-byte k";
    for (int i = 0; i < 16; i++) s[8*i +: 8] = sig[i];
    return {n, c, k, s};
  endfunction

  // Block core model: shift in 64 bytes, 1 copy + 160 round + 1 flush cycles, then ready.
  logic [511:0] core_buf = '0;
  logic [511:0] core_ks = '0;
  int           core_cnt = 0;
  logic         core_loaded = 1'b0;
  always @(posedge clk) begin
    if (!rst_n) begin
      core_loaded <= 1'b0;
      core_cnt    <= 0;
    end else if (core_write) begin
      core_buf    <= {core_data_in, core_buf[511:8]};
      core_cnt    <= 0;
      core_loaded <= 1'b1;
    end else if (core_cnt < 1000) begin
      core_cnt <= core_cnt + 1;
    end
    if (core_loaded && !core_write && core_cnt == 0) core_ks <= chacha(core_buf);
  end
  assign core_ready    = core_loaded && (core_cnt >= 162);
  assign core_data_out = core_ks[{core_addr, 3'b000} +: 8];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model: phase 0 idle, 1 loading, 2 waiting, 3 streaming.
  bit           m_valid = 1'b0;
  int           m_ph = 0, m_lk = 0, m_idx = 0, m_lat = -1, m_start_cyc = 0;
  bit           m_first = 1'b0, m_err = 1'b0, xfer_now = 1'b0;
  logic [255:0] m_key = '0;
  logic [95:0]  m_nonce = '0;
  logic [31:0]  m_ctr = '0, m_ctr_seen = '0;
  logic [511:0] m_img = '0, m_ks = '0;
  logic [7:0]   got [$];

  int    vld_pct = 100, rdy_pct = 100, pt_mode = 0, pt_pos = 0;
  string ladies = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";
  logic [7:0] nostall [68];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    xfer_now = 1'b0;
    if (m_valid) begin
      chk("busy", 32'(busy), 32'(m_ph != 0));
      chk("core_write", 32'(core_write), 32'(m_ph == 1));
      chk("err", 32'(err), 32'(m_err));
      chk("out_valid", 32'(out_valid), 32'(m_ph == 3 && in_valid));
      chk("in_ready", 32'(in_ready), 32'(m_ph == 3 && out_ready));
      if (m_ph == 1) chk("core_data_in", 32'(core_data_in), 32'(m_img[8*m_lk +: 8]));
      if (m_ph == 3) begin
        chk("core_addr", 32'(core_addr), 32'(m_idx));
        chk("out_data", 32'(out_data), 32'(in_data ^ m_ks[8*m_idx +: 8]));
      end else begin
        chk("out_data_idle", 32'(out_data), 32'd0);
      end
    end
    if (!rst_n) begin
      m_valid = 1'b1; m_ph = 0; m_lk = 0; m_idx = 0; m_err = 1'b0;
      m_key = '0; m_nonce = '0; m_ctr = '0;
    end else if (m_ph != 0 && stop) begin
      m_ph = 0;
    end else begin
      case (m_ph)
        0: begin
          if (cfg_we) begin
            if (cfg_addr < 32) m_key[8*cfg_addr +: 8] = cfg_data;
            else if (cfg_addr < 44) m_nonce[8*(cfg_addr-32) +: 8] = cfg_data;
            else if (cfg_addr < 48) m_ctr[8*(cfg_addr-44) +: 8] = cfg_data;
          end else if (start) begin
            m_ph = 1; m_lk = 0; m_err = 1'b0; m_first = 1'b1; m_start_cyc = cyc + 1;
            m_img = img(m_key, m_nonce, m_ctr);
          end
        end
        1: begin
          if (m_lk >= 48 && m_lk < 52) m_ctr_seen[8*(m_lk-48) +: 8] = core_data_in;
          m_lk++;
          if (m_lk == 64) begin
            m_ph = 2;
            m_ks = chacha(m_img);
          end
        end
        2: if (core_ready) begin m_ph = 3; m_idx = 0; end
        default: begin
          if (in_valid && out_ready) begin
            xfer_now = 1'b1;
            got.push_back(out_data);
            if (m_first) begin m_lat = cyc - m_start_cyc; m_first = 1'b0; end
            m_idx++;
            if (m_idx == 64) begin
              m_idx = 0;
              if (OVF_EN && m_ctr == 32'hffff_ffff) begin
                m_err = 1'b1; m_ctr = '0; m_ph = 0;
              end else begin
                m_ctr = m_ctr + 1; m_ph = 1; m_lk = 0;
                m_img = img(m_key, m_nonce, m_ctr);
              end
            end
          end
        end
      endcase
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    model_step();
    @(posedge clk);
    #1;
    if (xfer_now) pt_pos++;
    in_valid  = (vld_pct >= 100) ? 1'b1 : (int'($urandom_range(99)) < vld_pct);
    out_ready = (rdy_pct >= 100) ? 1'b1 : (int'($urandom_range(99)) < rdy_pct);
    if (pt_mode == 0) in_data = 8'd0;
    else if (pt_mode == 1) in_data = ladies[pt_pos % ladies.len()];
    else in_data = 8'($urandom_range(255));
  endtask

  task automatic cfg_write(input int addr, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = 6'(addr); cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic set_ctr(input logic [31:0] c);
    for (int i = 0; i < 4; i++) cfg_write(44 + i, c[8*i +: 8]);
  endtask

  task automatic load_rfc(input logic [7:0] nonce3);
    for (int i = 0; i < 32; i++) cfg_write(i, 8'(i));
    for (int i = 0; i < 12; i++) cfg_write(32 + i, (i == 3) ? nonce3 : (i == 7) ? 8'h4a : 8'h00);
    set_ctr(32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic run_xfers(input int n, input string name);
    int target, cnt;
    target = got.size() + n;
    cnt = 0;
    while (got.size() < target && cnt < 4000) begin tick(); cnt++; end
    n_chk++;
    if (got.size() < target) begin
      n_err++;
      $display("FAIL %s timeout: got %0d transfers, required %0d", name, n - (target - got.size()), n);
    end
  endtask

  initial begin
    int base, cnt;
    logic [511:0] ks;

    // Model pinned to the published keystream block.
    ks = chacha(img({<<8{256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f}},
                    {<<8{96'h000000090000004a00000000}}, 32'd1));
    chk("model_ks0", 32'(ks[31:0]), 32'he4e7f110);
    chk("model_ks63", 32'(ks[511:504]), 32'h4e);

    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_core_write", 32'(core_write), 32'd0);
    chk("rst_core_data_in", 32'(core_data_in), 32'd0);
    chk("rst_core_addr", 32'(core_addr), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);

    // Keystream vector with zero plaintext; cfg_we together with start must not start.
    load_rfc(8'h09);
    start = 1'b1; cfg_write(44, 8'h01); start = 1'b0;
    chk("cfg_start_ignored", 32'(busy), 32'd0);
    pt_mode = 0; pt_pos = 0; base = got.size();
    pulse_start();
    run_xfers(64, "rfc_ks");
    chk("rfc_ks_reload", 32'(core_write), 32'd1);
    pulse_stop();
    chk("rfc_ks_b0", 32'(got[base+0]), 32'h10);
    chk("rfc_ks_b1", 32'(got[base+1]), 32'hf1);
    chk("rfc_ks_b2", 32'(got[base+2]), 32'he7);
    chk("rfc_ks_b3", 32'(got[base+3]), 32'he4);
    chk("rfc_ks_b63", 32'(got[base+63]), 32'h4e);
    chk("first_latency", 32'(m_lat), 32'd227);

    // Encryption vector across a block boundary, no stalls.
    cfg_write(35, 8'h00);
    set_ctr(32'd1);
    pt_mode = 1; pt_pos = 0; base = got.size();
    pulse_start();
    run_xfers(68, "rfc_enc");
    pulse_stop();
    chk("rfc_enc_b0", 32'(got[base+0]), 32'h6e);
    chk("rfc_enc_b1", 32'(got[base+1]), 32'h2e);
    chk("rfc_enc_b2", 32'(got[base+2]), 32'h35);
    chk("rfc_enc_b3", 32'(got[base+3]), 32'h9a);
    chk("rfc_enc_b64", 32'(got[base+64]), 32'h07);
    for (int i = 0; i < 68; i++) nostall[i] = got[base+i];

    // Same plaintext under random valid/ready stalls.
    set_ctr(32'd1);
    vld_pct = 70; rdy_pct = 50; pt_pos = 0; base = got.size();
    pulse_start();
    run_xfers(68, "stall");
    pulse_stop();
    for (int i = 0; i < 68; i++) chk("stall_vs_nostall", 32'(got[base+i]), 32'(nostall[i]));
    vld_pct = 100; rdy_pct = 100;

    // Abort during LOAD, restart, and a config write attempted mid-stream.
    cfg_write(35, 8'h09);
    set_ctr(32'd1);
    pt_mode = 0;
    pulse_start();
    cnt = 0;
    while (!(m_ph == 1 && m_lk == 30) && cnt < 100) begin tick(); cnt++; end
    chk("abort_reach_lk30", 32'(m_lk), 32'd30);
    pulse_stop();
    chk("abort_busy", 32'(busy), 32'd0);
    base = got.size();
    pulse_start();
    run_xfers(3, "restart_a");
    cfg_write(0, 8'hff);
    run_xfers(3, "restart_b");
    pulse_stop();
    chk("restart_b0", 32'(got[base+0]), 32'h10);
    chk("restart_b3", 32'(got[base+3]), 32'he4);
    base = got.size();
    pulse_start();
    run_xfers(2, "key_kept");
    pulse_stop();
    chk("key_kept_b0", 32'(got[base]), 32'h10);

    // Block counter at all-ones.
    set_ctr(32'hffff_ffff);
    pt_mode = 2;
    pulse_start();
    run_xfers(64, "wrap");
`ifdef CHACHA_CTRL_OVERFLOW_EN
    chk("ovf_busy", 32'(busy), 32'd0);
    chk("ovf_err", 32'(err), 32'd1);
    m_ctr_seen = 32'hdeadbeef;
    pulse_start();
    repeat (53) tick();
    chk("ovf_err_cleared", 32'(err), 32'd0);
    chk("ovf_next_ctr", m_ctr_seen, 32'd0);
`else
    chk("wrap_busy", 32'(busy), 32'd1);
    m_ctr_seen = 32'hdeadbeef;
    repeat (53) tick();
    chk("wrap_next_ctr", m_ctr_seen, 32'd0);
`endif
    pulse_stop();

    // Reset in the middle of a streamed block clears config too.
    set_ctr(32'd1);
    pt_mode = 0;
    pulse_start();
    cnt = 0;
    while (!(m_ph == 3 && m_idx == 20) && cnt < 400) begin tick(); cnt++; end
    chk("rst_reach_idx20", 32'(m_idx), 32'd20);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_core_write", 32'(core_write), 32'd0);
    for (int i = 0; i < 12; i++) cfg_write(32 + i, (i == 3) ? 8'h09 : (i == 7) ? 8'h4a : 8'h00);
    set_ctr(32'd1);
    base = got.size();
    pulse_start();
    run_xfers(4, "zero_key");
    pulse_stop();
    n_chk++;
    if (got[base] == 8'h10) begin
      n_err++;
      $display("FAIL zero_key_b0: got %h, required anything but 10", got[base]);
    end
    for (int i = 0; i < 32; i++) cfg_write(i, 8'(i));
    base = got.size();
    pulse_start();
    run_xfers(4, "reloaded");
    pulse_stop();
    chk("reloaded_b0", 32'(got[base+0]), 32'h10);
    chk("reloaded_b3", 32'(got[base+3]), 32'he4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
